// File: rtl/serial_add_pkg.sv
// Shared constants and state encoding for the bit-serial adder.
package serial_add_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_add_full_adder.sv
// One-bit full adder used for the per-bit step of the serial add.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_add.sv
// Bit-serial adder: accepts two operands, adds them LSB-first over WIDTH
// cycles, then holds the sum, carry and overflow until the consumer takes them.
//
//   state | meaning
//   IDLE  | ready for operands, last result still on the outputs
//   RUN   | adding one bit pair per edge
//   DONE  | result valid, waiting for out_ready
module serial_add
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_sr;
  logic             c_q;
  logic [CW-1:0]    cnt;

  logic s_bit;
  logic c_bit;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (s_bit),
    .cout (c_bit)
  );

  // The sum is built in sum_sr so out/carry/ovf keep the previous result until
  // the last bit lands; at that edge a_q[0]/b_q[0] are the operand sign bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_sr    <= '0;
      c_q       <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            c_q      <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          c_q    <= c_bit;
          sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            out       <= {s_bit, sum_sr[WIDTH-1:1]};
            carry     <= c_bit;
            ovf       <= (a_q[0] == b_q[0]) && (s_bit != a_q[0]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add.sv
// Directed bench for serial_add: fixed vectors with hand-computed results.
module tb_serial_add;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out;
  logic         carry;
  logic         ovf;
  logic         out_valid;
  logic         out_ready;

  int checks   = 0;
  int failures = 0;

  serial_add #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .carry     (carry),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair, disturb inputs during RUN, check latency and
  // result, optionally stall in DONE, then drain back to IDLE.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eo, input logic ec, input logic ev,
                        input int hold);
    A        = a;
    B        = b;
    in_valid = 1'b1;
    check({tag, "_ready_idle"}, in_ready, 1);
    tick();
    check({tag, "_ready_run"}, in_ready, 0);
    for (int i = 0; i < W - 1; i++) begin
      A = W'($urandom);
      B = W'($urandom);
      out_ready = (i == 3);
      tick();
    end
    out_ready = 1'b0;
    check({tag, "_valid_early"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_out"}, out, eo);
    check({tag, "_carry"}, carry, ec);
    check({tag, "_ovf"}, ovf, ev);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_out"}, {ovf, carry, out}, {ev, ec, eo});
      check({tag, "_hold_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_exit_valid"}, out_valid, 0);
    check({tag, "_exit_ready"}, in_ready, 1);
    check({tag, "_keep"}, {ovf, carry, out}, {ev, ec, eo});
  endtask

  initial begin
    rst       = 1'b1;
    A         = '0;
    B         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_out", {ovf, carry, out}, 0);

    run_op("basic",  16'h03E8, 16'h00EA, 16'h04D2, 1'b0, 1'b0, 0);
    run_op("wrap",   16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 0);
    run_op("posovf", 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 0);
    run_op("negovf", 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 0);
    run_op("round",  16'hBBBC, 16'h5678, 16'h1234, 1'b1, 1'b0, 5);

    // Abort mid-RUN: after bits 0..7 have been processed.
    A        = 16'h1111;
    B        = 16'h2222;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", in_ready, 1);
    check("abort_valid", out_valid, 0);
    check("abort_out", {ovf, carry, out}, 0);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("abort_nopulse", out_valid, 0);
    end

    run_op("after", 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add.md
SERIAL_ADD -- requirements
Module: serial_add

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 16, as the operand and result width in bits.
REQ-002 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1, is the reset; it SHALL be synchronous and active-high.
REQ-004 Port A, input, WIDTH, is the first addend; it is sampled only on acceptance.
REQ-005 Port B, input, WIDTH, is the second addend; it is sampled only on acceptance.
REQ-006 Port in_valid, input, 1, SHALL indicate that A and B are valid.
REQ-007 Port in_ready, output, 1, SHALL indicate that the block can accept operands.
REQ-008 Port out, output, WIDTH, is the sum A+B modulo 2^WIDTH.
REQ-009 Port carry, output, 1, is the unsigned carry-out of the sum.
REQ-010 Port ovf, output, 1, is the two's-complement overflow flag.
REQ-011 Port out_valid, output, 1, SHALL indicate that out, carry and ovf are valid.
REQ-012 Port out_ready, input, 1, SHALL indicate that the consumer takes the result.

Function
REQ-013 The block SHALL be an FSM with states IDLE, RUN and DONE; reset state is IDLE.
REQ-014 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-015 Acceptance SHALL occur on an edge where the state is IDLE and in_valid=1.
REQ-016 On acceptance: latch A and B, clear the carry register and bit counter, go to RUN.
REQ-017 In RUN, each edge SHALL add one bit pair LSB-first with the registered carry and shift the sum bit into the result register MSB-side.
REQ-018 RUN SHALL last exactly WIDTH edges; the edge that processes bit WIDTH-1 SHALL move the state to DONE.
REQ-019 out_valid SHALL rise exactly WIDTH cycles after the acceptance edge.
REQ-020 carry SHALL equal the final carry.
REQ-021 ovf SHALL be 1 when A[MSB]==B[MSB] and out[MSB]!=A[MSB].
REQ-022 In DONE, out_valid SHALL be 1, and out, carry and ovf SHALL hold stable until out_ready=1.
REQ-023 On a DONE edge with out_ready=1, the block SHALL return to IDLE and clear out_valid.
REQ-024 The earliest next acceptance is the edge after DONE exits; there is no same-edge acceptance.
REQ-025 in_valid outside IDLE SHALL be ignored; A and B changes during RUN SHALL NOT affect the result.
REQ-026 out_ready outside DONE SHALL be ignored.
REQ-027 out, carry and ovf SHALL keep the last result after DONE exits until the next result overwrites them.
REQ-028 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap within one operation.

Reset
REQ-029 rst=1 on any edge SHALL force IDLE and set in_ready=1.
REQ-030 rst=1 SHALL clear out_valid, out, carry, ovf, the operand registers and the bit counter to 0.
REQ-031 Reset in RUN or DONE SHALL abort the operation with no out_valid pulse.
REQ-032 rst SHALL take priority over in_valid and out_ready on the same edge.

Structure
REQ-033 A shared package serial_add_pkg SHALL hold the WIDTH default constant and the state enum typedef (IDLE, RUN, DONE).
REQ-034 A single sub-module full_adder (a, b, cin -> s, cout) SHALL be instantiated for the per-bit add.

Verification
REQ-035 A=0x03E8, B=0x00EA -> out=0x04D2, carry=0, ovf=0, with out_valid 16 cycles after acceptance.
REQ-036 A=0xFFFF, B=0x0001 -> out=0x0000, carry=1, ovf=0.
REQ-037 A=0x7FFF, B=0x0001 -> out=0x8000, carry=0, ovf=1; and A=0x8000, B=0x8000 -> out=0x0000, carry=1, ovf=1.
REQ-038 Round-trip: A=0x1234, B=0x5678 gives difference 0xBBBC; 0xBBBC+0x5678 -> out=0x1234, carry=1, ovf=0.
REQ-039 Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, outputs stay stable, and in_ready stays 0 while in_valid=1; release -> IDLE on the next edge.
REQ-040 Assert rst after bit 7 of a RUN -> next cycle IDLE, outputs 0, no out_valid; a new operation then yields a correct sum.
